// File: rtl/uc_multiciclo_if.sv
// Control/datapath bundle of the multicycle MIPS control unit.
// master = control unit (drives the enables), slave = datapath side.
interface uc_multiciclo_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
);
  logic [OP_W-1:0]    opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               ir_write;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               branch;
  logic               jump;
  logic               illegal_op;
  logic [3:0]         state_dbg;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           branch, jump, illegal_op, state_dbg, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           branch, jump, illegal_op, state_dbg, instr_count
  );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle MIPS control unit: Moore FSM with memory-ready stalls and illegal-opcode pulse.
// Optional retired-instruction counter enabled by defining UC_PERF_CNT_EN.
module uc_multiciclo #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input logic            clk,
  input logic            rst_n,
  uc_multiciclo_if.master bus
);
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_EXEC_R    = 4'd3;
  localparam logic [3:0] S_EXEC_I    = 4'd4;
  localparam logic [3:0] S_MEM_ADDR  = 4'd5;
  localparam logic [3:0] S_MEM_READ  = 4'd6;
  localparam logic [3:0] S_MEM_WB    = 4'd7;
  localparam logic [3:0] S_MEM_WRITE = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JUMP      = 4'd10;
  localparam logic [3:0] S_WB_ALU    = 4'd11;

  // Full-width compare: any nonzero bit above [5:0] fails every match.
  localparam logic [OP_W-1:0] OP_R   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_I   = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] OP_LWI = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(6'b101010);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(6'b000110);
  localparam logic [OP_W-1:0] OP_J   = OP_W'(6'b010000);

  localparam logic [ALUOP_W-1:0] ALU_ARITH = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_ADDR  = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_BEQ   = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_BNE   = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_PC4   = ALUOP_W'(3'b110);

  logic [3:0]      state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [3:0]      dec_nxt;
  logic            dec_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
    end
  end

  always_comb begin
    dec_nxt = S_FETCH;
    dec_ill = 1'b0;
    case (bus.opcode)
      OP_R:                dec_nxt = S_EXEC_R;
      OP_I:                dec_nxt = S_EXEC_I;
      OP_LW, OP_LWI, OP_SW: dec_nxt = S_MEM_ADDR;
      OP_BEQ, OP_BNE:      dec_nxt = S_BRANCH;
      OP_J:                dec_nxt = S_JUMP;
      default:             dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE:    state_d = dec_nxt;
      S_EXEC_R:    state_d = S_WB_ALU;
      S_EXEC_I:    state_d = S_WB_ALU;
      S_MEM_ADDR:  state_d = (op_q == OP_LW)  ? S_MEM_READ :
                             (op_q == OP_LWI) ? S_WB_ALU   : S_MEM_WRITE;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_WB_ALU:    state_d = S_FETCH;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.ir_write      = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = ALU_ARITH;
    bus.branch        = 1'b0;
    bus.jump          = 1'b0;
    bus.illegal_op    = 1'b0;
    bus.state_dbg     = state_q;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = ALU_PC4;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b  = 2'b10;
        bus.illegal_op = dec_ill;
      end
      S_EXEC_R: bus.alu_src_a = 1'b1;
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = ALU_ADDR;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.pc_write_cond = 1'b1;
        bus.branch        = 1'b1;
        bus.alu_op        = (op_q == OP_BEQ) ? ALU_BEQ : ALU_BNE;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.jump     = 1'b1;
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (op_q != OP_LWI);
      end
      default: ;
    endcase
  end

`ifdef UC_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  // Illegal opcodes reach FETCH from DECODE, so they never qualify here.
  assign retire = (state_d == S_FETCH) &&
                  (state_q == S_MEM_WB || state_q == S_WB_ALU || state_q == S_BRANCH ||
                   state_q == S_JUMP   || state_q == S_MEM_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.instr_count = cnt_q;
`else
  assign bus.instr_count = '0;
`endif
endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Parametrised multicycle successor to the single-cycle MIPS control unit.
- Sequences each instruction through a Moore FSM: fetch, decode, execute, memory, write-back.
- Adds memory-ready stalls, an illegal-opcode flag and a state-visible debug port.
- Drives the multicycle datapath enables: PC, IR, register file, memory and ALU source muxes.

Parameters:
OP_W, 6, opcode width; bits above [5:0] must be 0 for a legal opcode
ALUOP_W, 3, width of alu_op output (>=3)
CNT_W, 32, retired-instruction counter width (PERF_CNT_EN only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
opcode  in  OP_W  instruction opcode from IR, sampled in DECODE
mem_ready  in  1  memory handshake; access completes in a cycle where it is 1
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  conditional PC load (branch)
ir_write  out  1  load IR
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_to_reg  out  1  write-back source: 1=MDR
reg_dst  out  1  destination select: 1=rd
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm
alu_op  out  ALUOP_W  ALU op: 000 arith/R/I, 011 address add, 100 beq, 101 bne, 110 PC+4
branch  out  1  branch-type flag to PC logic
jump  out  1  PC source = jump target
illegal_op  out  1  one-cycle pulse on unknown opcode
state_dbg  out  4  current state encoding
instr_count  out  CNT_W  retired instructions; optional, see below

Behaviour:
- Reset value of every output is 0; FSM goes to IDLE asynchronously on rst_n=0, including mid-instruction.
- Outputs are decoded combinationally from the state register, op_q and mem_ready; no output is registered separately.
- State encodings are IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_READ=6, MEM_WB=7, MEM_WRITE=8, BRANCH=9, JUMP=10, WB_ALU=11.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=110. ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: latch opcode into op_q. alu_src_a=0, alu_src_b=10 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC_R
  - 000001 -> EXEC_I
  - 100010 (lw), 100011 (lwi), 101010 (sw) -> MEM_ADDR
  - 000100 (beq), 000110 (bne) -> BRANCH
  - 010000 -> JUMP
  - any other value, including nonzero upper bits -> illegal_op=1 for this cycle, next state FETCH
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=000. Next state WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=000. Next state WB_ALU.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=011. Next state is MEM_READ for lw, WB_ALU for lwi, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready=1, then FETCH.
- WB_ALU: reg_write=1, mem_to_reg=0. reg_dst=1 for R and I types, 0 for lwi. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, pc_write_cond=1, branch=1. alu_op=100 (beq) or 101 (bne). Next state FETCH.
- JUMP: pc_write=1, jump=1. Next state FETCH.
- Latency with mem_ready=1, from FETCH back to FETCH:
  - R, I, lwi, sw: 4 cycles
  - lw: 5 cycles
  - beq, bne, j: 3 cycles
  - each cycle mem_ready=0 adds one cycle.
- alu_op constants are zero-extended to ALUOP_W.

Optional Feature:
- Macro: UC_PERF_CNT_EN.
- Defined: instr_count increments by 1 on each retire, i.e. the transition from MEM_WB, WB_ALU, BRANCH, JUMP, or MEM_WRITE with mem_ready=1, into FETCH.
  - Illegal opcodes do not count.
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared by reset.
- Undefined: instr_count port remains and is tied to 0; no counter flops are synthesised.

Test Plan:
- Reset: rst_n=0, then released; mem_ready=1 -> all outputs 0 during reset; state_dbg sequence 0,1,2.
- R-type: opcode=000000, mem_ready=1 -> state_dbg 1,2,3,11,1; reg_write=1 with reg_dst=1 in state 11 only; instr_count=1.
- lw with stall: opcode=100010, mem_ready=0 for 2 cycles in MEM_READ -> states 1,2,5,6,6,6,7,1; mem_to_reg=1 in state 7.
- sw then bne: sw holds mem_write=1 until mem_ready=1; bne gives alu_op=101 with pc_write_cond=1 in state 9; instr_count=2.
- Illegal: opcode=111111 -> illegal_op high exactly one cycle in DECODE; next state FETCH; no reg_write or mem_write; counter unchanged.
- Reset mid-op: rst_n=0 asserted in MEM_WRITE -> mem_write drops to 0 asynchronously the same cycle; state_dbg=0.
